// File: rtl/exc_entry_seq_if.sv
// Core data bus as seen by the exception-entry sequencer.
// The sequencer is the master. The slave is the memory system.
//
// Handshake: the master raises bus_req and presents bus_we/bus_addr/bus_wdata.
// The master holds all of these unchanged until bus_ack is sampled high at a posedge.
// bus_ack only has meaning while bus_req=1.
// bus_err and bus_rdata only have meaning in a cycle where bus_ack=1.
// A new beat may be presented in the cycle right after an ack.
interface exc_entry_seq_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_err,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_err,
    output bus_rdata
  );
endinterface

// File: rtl/exc_entry_seq.sv
// Exception-entry sequencer: stacks the 8-word frame, fetches the handler vector,
// then strobes the new PC/LR/SP/IPSR into the core. A bus error during entry locks up.
module exc_entry_seq #(
  parameter logic [31:0] VTOR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  irq_valid,
  input  logic [7:0]            irq_num,
  output logic                  irq_ack,
  output logic                  busy,
  input  logic [31:0]           sp_in,
  output logic [2:0]            reg_rd_idx,
  input  logic [31:0]           reg_rd_data,
  exc_entry_seq_if.master       bus,
  output logic                  exc_load,
  output logic [31:0]           pc_value,
  output logic [31:0]           lr_value,
  output logic [31:0]           sp_value,
  output logic [5:0]            ipsr_value,
  output logic                  lockup,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STACK = 3'd1,
    S_VEC   = 3'd2,
    S_DONE  = 3'd3,
    S_LOCK  = 3'd4
  } state_e;

  localparam logic [31:0] EXC_RETURN = 32'hFFFF_FFF9;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [31:0] base_q;
  logic        align_q;
  logic [4:0]  num_q;
  logic        irq_ack_q;
  logic        busy_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic        load_q;
  logic [31:0] pc_q;
  logic [31:0] lr_q;
  logic [31:0] sp_q;
  logic [5:0]  ipsr_q;
  logic        lockup_q;

  logic        accept_d;
  logic        align_d;
  logic [31:0] sp_adj_d;
  logic [31:0] base_d;
  logic [5:0]  exc_num_d;
  logic [31:0] vec_addr_d;
  logic [31:0] xpsr_d;

  // The frame base is 8-byte aligned.
  // A 4-byte pad is inserted when the incoming SP is only word aligned.
  assign align_d    = sp_in[2];
  assign sp_adj_d   = sp_in - 32'd32 - (align_d ? 32'd4 : 32'd0);
  assign base_d     = sp_adj_d & ~32'h0000_0007;
  assign accept_d   = irq_valid && (irq_num[7:5] == 3'b000) && !lockup_q;
  assign exc_num_d  = 6'd16 + {1'b0, num_q};
  assign vec_addr_d = VTOR + {24'd0, exc_num_d, 2'b00};

  // The stacked xPSR carries the alignment pad flag in bit 9.
  // This lets exception return undo the pad.
  assign xpsr_d = {reg_rd_data[31:10], align_q, reg_rd_data[8:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      base_q    <= 32'h0;
      align_q   <= 1'b0;
      num_q     <= 5'd0;
      irq_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      load_q    <= 1'b0;
      pc_q      <= 32'h0;
      lr_q      <= 32'h0;
      sp_q      <= 32'h0;
      ipsr_q    <= 6'd0;
      lockup_q  <= 1'b0;
    end else begin
      irq_ack_q <= 1'b0;
      load_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            state_q   <= S_STACK;
            num_q     <= irq_num[4:0];
            base_q    <= base_d;
            align_q   <= align_d;
            idx_q     <= 3'd0;
            irq_ack_q <= 1'b1;
            busy_q    <= 1'b1;
            req_q     <= 1'b1;
            we_q      <= 1'b1;
            addr_q    <= base_d;
          end
        end
        S_STACK: begin
          if (bus.bus_ack) begin
            if (bus.bus_err) begin
              state_q  <= S_LOCK;
              lockup_q <= 1'b1;
              busy_q   <= 1'b0;
              req_q    <= 1'b0;
              we_q     <= 1'b0;
              addr_q   <= 32'h0;
              idx_q    <= 3'd0;
            end else if (idx_q == 3'd7) begin
              state_q <= S_VEC;
              idx_q   <= 3'd0;
              we_q    <= 1'b0;
              addr_q  <= vec_addr_d;
            end else begin
              idx_q  <= idx_q + 3'd1;
              addr_q <= addr_q + 32'd4;
            end
          end
        end
        S_VEC: begin
          if (bus.bus_ack) begin
            req_q  <= 1'b0;
            addr_q <= 32'h0;
            if (bus.bus_err) begin
              state_q  <= S_LOCK;
              lockup_q <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              state_q <= S_DONE;
              load_q  <= 1'b1;
              pc_q    <= bus.bus_rdata & ~32'h0000_0001;
              lr_q    <= EXC_RETURN;
              sp_q    <= base_q;
              ipsr_q  <= exc_num_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          pc_q    <= 32'h0;
          lr_q    <= 32'h0;
          sp_q    <= 32'h0;
          ipsr_q  <= 6'd0;
        end
        S_LOCK: begin
          state_q <= S_LOCK;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign irq_ack       = irq_ack_q;
  assign busy          = busy_q;
  assign reg_rd_idx    = idx_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = (state_q == S_STACK) ? ((idx_q == 3'd7) ? xpsr_d : reg_rd_data) : 32'h0;
  assign exc_load      = load_q;
  assign pc_value      = pc_q;
  assign lr_value      = lr_q;
  assign sp_value      = sp_q;
  assign ipsr_value    = ipsr_q;
  assign lockup        = lockup_q;
  assign dbg_state     = state_q;

endmodule
